// File: rtl/vga_line_prefetch_ctrl.sv
// -----------------------------------------------------------------------------
// vga_line_prefetch_ctrl
//
// Prefetches one video row from SDRAM into a ping-pong line buffer, one row
// ahead of the display. At the start of each eligible scan line (iVGA_X == 0),
// the next row is fetched as H_ACT/BURST_LEN consecutive burst reads. Each
// returned beat is written straight into the line-buffer bank selected by the
// row's parity. The display reads the opposite bank.
//
// Ports
//   iCLK, iRST          clock, asynchronous active-high reset
//   iEnable             low: no new fetch starts; an open request is withdrawn
//   iVGA_X, iVGA_Y      current raster position, blanking included
//   oRd_Req/oRd_Addr    burst request and start word address to the arbiter
//   iRd_Gnt             one-cycle acceptance of the pending burst
//   iRd_Valid/iRd_Data  returned data beats, {R,G,B} 10 bits each
//   oLB_Wr_*            line-buffer write port (enable, bank, address, data)
//   oLB_Rd_Bank         bank the display is currently reading
//   oBusy               a fetch is in progress
//   oLine_Done          pulse after the last word of a row is written
//   oFrame_Done         pulse together with oLine_Done for the last row
//   oUnderrun           sticky: a new line started before the fetch finished
//   iUnderrun_Clr       clears oUnderrun (a simultaneous new overrun wins)
// -----------------------------------------------------------------------------
module vga_line_prefetch_ctrl #(
    parameter int          H_ACT         = 640,
    parameter int          V_ACT         = 480,
    parameter int          VIDEO_START_Y = 100,
    parameter int          BURST_LEN     = 8,
    parameter logic [21:0] FRAME_BASE    = 22'h0
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iEnable,
    input  logic [10:0] iVGA_X,
    input  logic [10:0] iVGA_Y,
    output logic        oRd_Req,
    input  logic        iRd_Gnt,
    output logic [21:0] oRd_Addr,
    input  logic        iRd_Valid,
    input  logic [29:0] iRd_Data,
    output logic        oLB_Wr_En,
    output logic        oLB_Wr_Bank,
    output logic [9:0]  oLB_Wr_Addr,
    output logic [29:0] oLB_Wr_Data,
    output logic        oLB_Rd_Bank,
    output logic        oBusy,
    output logic        oLine_Done,
    output logic        oFrame_Done,
    output logic        oUnderrun,
    input  logic        iUnderrun_Clr
);

    localparam logic [10:0] TRIG_Y_MIN   = 11'(VIDEO_START_Y - 1);
    localparam logic [10:0] TRIG_Y_MAX   = 11'(V_ACT - 2);
    localparam logic [10:0] START_Y      = 11'(VIDEO_START_Y);
    localparam logic [8:0]  LAST_ROW     = 9'(V_ACT - VIDEO_START_Y - 1);
    localparam logic [9:0]  LAST_WORD    = 10'(H_ACT - 1);
    localparam logic [9:0]  BEAT_MASK    = 10'(BURST_LEN - 1);
    localparam logic [21:0] LINE_STRIDE  = 22'(H_ACT);
    localparam logic [21:0] BURST_STRIDE = 22'(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } stateT;

    stateT       stateReg, stateNext;
    logic [8:0]  rowReg, rowNext;
    logic [9:0]  wordCntReg, wordCntNext;
    logic [21:0] addrReg, addrNext;
    logic        busyReg;
    logic        lineDoneReg, lineDoneNext;
    logic        frameDoneReg, frameDoneNext;
    logic        underrunReg;

    logic        trigger;
    logic [8:0]  trigRow;
    logic        wrEn;
    logic        lastBeat;
    logic        rowComplete;

    assign trigger = iEnable && (iVGA_X == 11'd0) &&
                     (iVGA_Y >= TRIG_Y_MIN) && (iVGA_Y <= TRIG_Y_MAX);
    // The row fetched is the one displayed on the following scan line.
    assign trigRow = 9'(iVGA_Y + 11'd1 - START_Y);

    assign wrEn = (stateReg == DATA) && iRd_Valid;
    // Bursts are aligned to BURST_LEN, so the low word-counter bits are the
    // beat index within the current burst.
    assign lastBeat    = (wordCntReg & BEAT_MASK) == BEAT_MASK;
    assign rowComplete = wordCntReg == LAST_WORD;

    always_comb begin
        stateNext     = stateReg;
        rowNext       = rowReg;
        wordCntNext   = wordCntReg;
        addrNext      = addrReg;
        lineDoneNext  = 1'b0;
        frameDoneNext = 1'b0;
        case (stateReg)
            IDLE: begin
                if (trigger) begin
                    stateNext   = REQ;
                    rowNext     = trigRow;
                    wordCntNext = 10'd0;
                    addrNext    = FRAME_BASE + 22'(trigRow) * LINE_STRIDE;
                end
            end
            REQ: begin
                // Withdrawing the enable takes precedence over a grant.
                if (!iEnable) begin
                    stateNext = IDLE;
                end else if (iRd_Gnt) begin
                    stateNext = DATA;
                end
            end
            DATA: begin
                if (iRd_Valid) begin
                    wordCntNext = wordCntReg + 10'd1;
                    if (lastBeat) begin
                        if (rowComplete) begin
                            stateNext     = IDLE;
                            lineDoneNext  = 1'b1;
                            frameDoneNext = (rowReg == LAST_ROW);
                        end else if (iEnable) begin
                            stateNext = REQ;
                            addrNext  = addrReg + BURST_STRIDE;
                        end else begin
                            stateNext = IDLE;
                        end
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            stateReg     <= IDLE;
            rowReg       <= 9'd0;
            wordCntReg   <= 10'd0;
            addrReg      <= 22'd0;
            busyReg      <= 1'b0;
            lineDoneReg  <= 1'b0;
            frameDoneReg <= 1'b0;
            underrunReg  <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            rowReg       <= rowNext;
            wordCntReg   <= wordCntNext;
            addrReg      <= addrNext;
            busyReg      <= (stateNext != IDLE);
            lineDoneReg  <= lineDoneNext;
            frameDoneReg <= frameDoneNext;
            // A new overrun outranks a clear in the same cycle.
            if (trigger && busyReg) begin
                underrunReg <= 1'b1;
            end else if (iUnderrun_Clr) begin
                underrunReg <= 1'b0;
            end
        end
    end

    // Write data is gated so the port idles at zero between beats and in reset.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : gChan
            assign oLB_Wr_Data[gi*10 +: 10] = wrEn ? iRd_Data[gi*10 +: 10] : 10'd0;
        end
    endgenerate

    assign oRd_Req     = (stateReg == REQ);
    assign oRd_Addr    = addrReg;
    assign oLB_Wr_En   = wrEn;
    assign oLB_Wr_Bank = rowReg[0];
    assign oLB_Wr_Addr = wordCntReg;
    assign oBusy       = busyReg;
    assign oLine_Done  = lineDoneReg;
    assign oFrame_Done = frameDoneReg;
    assign oUnderrun   = underrunReg;
    // Bit 0 of (iVGA_Y - START_Y) is the XOR of the two operands' bit 0.
    assign oLB_Rd_Bank = (iVGA_Y >= START_Y) && (iVGA_Y[0] ^ START_Y[0]);

endmodule

// File: tb/tb_vga_line_prefetch_ctrl.sv
module tb_vga_line_prefetch_ctrl;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iEnable;
    logic [10:0] iVGA_X;
    logic [10:0] iVGA_Y;
    logic        oRd_Req;
    logic        iRd_Gnt;
    logic [21:0] oRd_Addr;
    logic        iRd_Valid;
    logic [29:0] iRd_Data;
    logic        oLB_Wr_En;
    logic        oLB_Wr_Bank;
    logic [9:0]  oLB_Wr_Addr;
    logic [29:0] oLB_Wr_Data;
    logic        oLB_Rd_Bank;
    logic        oBusy;
    logic        oLine_Done;
    logic        oFrame_Done;
    logic        oUnderrun;
    logic        iUnderrun_Clr;

    int checks = 0;
    int errors = 0;
    bit expUnder = 1'b0;

    vga_line_prefetch_ctrl dut (
        .iCLK          (iCLK),
        .iRST          (iRST),
        .iEnable       (iEnable),
        .iVGA_X        (iVGA_X),
        .iVGA_Y        (iVGA_Y),
        .oRd_Req       (oRd_Req),
        .iRd_Gnt       (iRd_Gnt),
        .oRd_Addr      (oRd_Addr),
        .iRd_Valid     (iRd_Valid),
        .iRd_Data      (iRd_Data),
        .oLB_Wr_En     (oLB_Wr_En),
        .oLB_Wr_Bank   (oLB_Wr_Bank),
        .oLB_Wr_Addr   (oLB_Wr_Addr),
        .oLB_Wr_Data   (oLB_Wr_Data),
        .oLB_Rd_Bank   (oLB_Rd_Bank),
        .oBusy         (oBusy),
        .oLine_Done    (oLine_Done),
        .oFrame_Done   (oFrame_Done),
        .oUnderrun     (oUnderrun),
        .iUnderrun_Clr (iUnderrun_Clr)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge iCLK);
        #1;
    endtask

    task automatic idleInputs();
        iVGA_X        = 11'd1;
        iRd_Gnt       = 1'b0;
        iRd_Valid     = 1'b0;
        iRd_Data      = 30'd0;
        iUnderrun_Clr = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_ctrl"}, 64'({oRd_Req, oLB_Wr_En, oLB_Wr_Bank, oBusy,
                                   oLine_Done, oFrame_Done, oUnderrun}), 64'd0);
        check({tag, "_rdaddr"}, 64'(oRd_Addr), 64'd0);
        check({tag, "_wraddr"}, 64'(oLB_Wr_Addr), 64'd0);
        check({tag, "_wrdata"}, 64'(oLB_Wr_Data), 64'd0);
    endtask

    // Full row fetch from line y with a randomised SDRAM. Optionally a second
    // trigger (and a clear) is injected in the first request cycle of a burst.
    task automatic doFetch(input int y, input int injectBurst, input bit injectClr);
        int row;
        int word;
        int lat;
        int b;
        logic [29:0] d;
        row  = y + 1 - 100;
        word = 0;
        idleInputs();
        iEnable = 1'b1;
        iVGA_Y  = 11'(y);
        iVGA_X  = 11'd0;
        @(negedge iCLK);
        check("trig_cycle_req", 64'(oRd_Req), 64'd0);
        nextCycle();
        iVGA_X = 11'd1;
        for (int k = 0; k < 80; k++) begin
            lat = int'($urandom_range(0, 3));
            for (int c = 0; c <= lat; c++) begin
                if (k == injectBurst && c == 0) begin
                    iVGA_X        = 11'd0;
                    iUnderrun_Clr = injectClr;
                end
                iRd_Gnt = (c == lat);
                @(negedge iCLK);
                check("req_high", 64'(oRd_Req), 64'd1);
                check("req_addr", 64'(oRd_Addr), 64'(row * 640 + k * 8));
                check("req_busy", 64'(oBusy), 64'd1);
                check("req_no_write", 64'(oLB_Wr_En), 64'd0);
                check("req_no_line_done", 64'(oLine_Done), 64'd0);
                check("req_underrun", 64'(oUnderrun), 64'(expUnder));
                nextCycle();
                if (k == injectBurst && c == 0) expUnder = 1'b1;
                iVGA_X        = 11'd1;
                iUnderrun_Clr = 1'b0;
                iRd_Gnt       = 1'b0;
            end
            b = 0;
            while (b < 8) begin
                if ($urandom_range(0, 3) == 0) begin
                    iRd_Valid = 1'b0;
                    @(negedge iCLK);
                    check("gap_no_write", 64'(oLB_Wr_En), 64'd0);
                    nextCycle();
                end else begin
                    d         = 30'($urandom);
                    iRd_Valid = 1'b1;
                    iRd_Data  = d;
                    @(negedge iCLK);
                    check("beat_write", 64'({oLB_Wr_En, oLB_Wr_Addr, oLB_Wr_Bank, oLB_Wr_Data}),
                          64'({1'b1, 10'(word), 1'(row % 2), d}));
                    nextCycle();
                    iRd_Valid = 1'b0;
                    word++;
                    b++;
                end
            end
        end
        @(negedge iCLK);
        check("line_done", 64'(oLine_Done), 64'd1);
        check("frame_done", 64'(oFrame_Done), 64'(row == 379));
        check("end_busy", 64'({oBusy, oRd_Req}), 64'd0);
        nextCycle();
        @(negedge iCLK);
        check("line_done_pulse", 64'({oLine_Done, oFrame_Done}), 64'd0);
        nextCycle();
        $display("fetch y=%0d row=%0d words=%0d underrun=%0b", y, row, word, oUnderrun);
    endtask

    initial begin
        int y;
        logic [29:0] d;

        // Reset state
        iRST    = 1'b1;
        iEnable = 1'b0;
        iVGA_Y  = 11'd0;
        idleInputs();
        #1;
        checkAllZero("reset");
        repeat (3) nextCycle();
        iRST = 1'b0;
        $display("reset released");

        // Spurious grant / valid in IDLE
        iRd_Gnt   = 1'b1;
        iRd_Valid = 1'b1;
        iRd_Data  = 30'h3ABCDEF;
        iEnable   = 1'b1;
        @(negedge iCLK);
        check("idle_valid_no_write", 64'(oLB_Wr_En), 64'd0);
        nextCycle();
        @(negedge iCLK);
        check("idle_gnt_no_req", 64'({oRd_Req, oBusy, oLB_Wr_En}), 64'd0);
        nextCycle();
        idleInputs();
        $display("spurious gnt/valid in idle");

        // Triggers that must not start a fetch
        begin
            int badY[4] = '{99, 50, 479, 98};
            bit badEn[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
            for (int i = 0; i < 4; i++) begin
                iEnable = badEn[i];
                iVGA_Y  = 11'(badY[i]);
                iVGA_X  = 11'd0;
                nextCycle();
                iVGA_X = 11'd1;
                @(negedge iCLK);
                check("no_trigger", 64'({oRd_Req, oBusy}), 64'd0);
                nextCycle();
                $display("non-trigger y=%0d en=%0b", badY[i], badEn[i]);
            end
        end

        // Display read bank
        for (int i = 0; i < 15; i++) begin
            if (i < 3) y = 99 + i;
            else y = int'($urandom_range(0, 524));
            iVGA_Y = 11'(y);
            #1;
            check("rd_bank", 64'(oLB_Rd_Bank), 64'((y >= 100) ? ((y - 100) % 2) : 0));
            $display("rd_bank y=%0d bank=%0b", y, oLB_Rd_Bank);
        end
        nextCycle();

        // Full rows: first, last, and overrun cases
        doFetch(99, -1, 1'b0);
        doFetch(478, -1, 1'b0);
        doFetch(int'($urandom_range(100, 477)), 5, 1'b0);
        doFetch(int'($urandom_range(100, 477)), 40, 1'b1);

        // Plain clear
        iUnderrun_Clr = 1'b1;
        nextCycle();
        iUnderrun_Clr = 1'b0;
        expUnder = 1'b0;
        @(negedge iCLK);
        check("underrun_clear", 64'(oUnderrun), 64'd0);
        nextCycle();
        $display("underrun cleared");

        // Enable dropped in REQ
        iEnable = 1'b1;
        iVGA_Y  = 11'd150;
        iVGA_X  = 11'd0;
        nextCycle();
        iVGA_X  = 11'd1;
        iEnable = 1'b0;
        @(negedge iCLK);
        check("en_req_before", 64'(oRd_Req), 64'd1);
        nextCycle();
        @(negedge iCLK);
        check("en_req_dropped", 64'({oRd_Req, oBusy}), 64'd0);
        nextCycle();
        for (int i = 0; i < 4; i++) begin
            iRd_Gnt   = 1'b1;
            iRd_Valid = 1'b1;
            iRd_Data  = 30'($urandom);
            @(negedge iCLK);
            check("en_req_no_write", 64'({oLB_Wr_En, oRd_Req}), 64'd0);
            nextCycle();
        end
        idleInputs();
        $display("enable low in REQ");

        // Enable dropped in DATA after beat 3 (row 101, bank 1)
        iEnable = 1'b1;
        iVGA_Y  = 11'd200;
        iVGA_X  = 11'd0;
        nextCycle();
        iVGA_X  = 11'd1;
        iRd_Gnt = 1'b1;
        @(negedge iCLK);
        check("en_data_addr", 64'({oRd_Req, oRd_Addr}), 64'({1'b1, 22'(101 * 640)}));
        nextCycle();
        iRd_Gnt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) iEnable = 1'b0;
            d         = 30'($urandom);
            iRd_Valid = 1'b1;
            iRd_Data  = d;
            @(negedge iCLK);
            check("en_data_beat", 64'({oLB_Wr_En, oLB_Wr_Addr, oLB_Wr_Bank, oLB_Wr_Data}),
                  64'({1'b1, 10'(i), 1'b1, d}));
            nextCycle();
        end
        iRd_Valid = 1'b0;
        @(negedge iCLK);
        check("en_data_idle", 64'({oBusy, oRd_Req, oLine_Done}), 64'd0);
        nextCycle();
        iRd_Valid = 1'b1;
        @(negedge iCLK);
        check("en_data_no_write", 64'(oLB_Wr_En), 64'd0);
        nextCycle();
        idleInputs();
        $display("enable low in DATA after beat 3");

        // Reset pulse in DATA
        iEnable = 1'b1;
        iVGA_Y  = 11'd120;
        iVGA_X  = 11'd0;
        nextCycle();
        iVGA_X  = 11'd1;
        iRd_Gnt = 1'b1;
        nextCycle();
        iRd_Gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iRd_Valid = 1'b1;
            iRd_Data  = 30'($urandom) | 30'd1;
            #1;
            check("rst_pre_write", 64'(oLB_Wr_En), 64'd1);
            if (i < 2) nextCycle();
        end
        iRST = 1'b1;
        #1;
        checkAllZero("rst_mid");
        nextCycle();
        iRST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            iRd_Valid = 1'b1;
            iRd_Data  = 30'($urandom);
            @(negedge iCLK);
            check("rst_after_no_write", 64'({oLB_Wr_En, oRd_Req, oBusy}), 64'd0);
            nextCycle();
        end
        idleInputs();
        $display("reset pulse in DATA");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
